// File: rtl/dark_arb_pkg.sv
// Shared types and constants for the darksoc memory-bus arbiter.
package dark_arb_pkg;

  // Arbiter transaction phases: pick a winner, wait on the bus, hand back the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int          ARB_NREQ_MAX        = 8;
  localparam logic [31:0] ARB_ERR_DATA        = 32'hDEAD_BEEF;
  localparam int          ARB_TIMEOUT_CYC_DEF = 255;

  // Next round-robin position after idx, wrapping at n
  function automatic int arb_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dark_mem_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the shared
// memory/IO bus. The arbiter uses the slave view; the master view is the
// environment side (masters plus memory).
interface dark_mem_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  localparam int IW = $clog2(NREQ);

  // requester side
  logic [NREQ-1:0]              req;
  logic [NREQ-1:0]              we;
  logic [NREQ-1:0][AW-1:0]      addr;
  logic [NREQ-1:0][DW-1:0]      wdata;
  logic [NREQ-1:0][DW/8-1:0]    be;
  logic [NREQ-1:0]              ack;
  logic [DW-1:0]                rdata;
  logic                         err;
  logic [IW-1:0]                gnt_id;

  // shared bus side
  logic                         mem_req;
  logic                         mem_we;
  logic [AW-1:0]                mem_addr;
  logic [DW-1:0]                mem_wdata;
  logic [DW/8-1:0]              mem_be;
  logic                         mem_ack;
  logic [DW-1:0]                mem_rdata;

  modport slave (
    input  req, we, addr, wdata, be, mem_ack, mem_rdata,
    output ack, rdata, err, gnt_id, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output req, we, addr, wdata, be, mem_ack, mem_rdata,
    input  ack, rdata, err, gnt_id, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/dark_rr_picker.sv
// Combinational round-robin picker: returns the first set request at or
// after the pointer, wrapping from N-1 back to 0. Kept generic so other
// schedulers can reuse it.
module dark_rr_picker #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_rr_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_winner
);

  logic [IW-1:0] w_idx [N];
  logic [N-1:0]  w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      // gi-th candidate in rotated order: (ptr + gi) mod N without a divider
      logic [IW:0] w_sum;
      assign w_sum     = {1'b0, i_rr_ptr} + (IW+1)'(gi);
      assign w_idx[gi] = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
      assign w_hit[gi] = i_req[w_idx[gi]];
    end
  endgenerate

  // Lowest rotated slot with a request wins; scan downward so it lands last
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_valid  = 1'b1;
        o_winner = w_idx[k];
      end
    end
  end

endmodule

// File: rtl/dark_mem_arbiter.sv
// Round-robin arbiter serialising NREQ masters onto the single darksoc
// memory/IO bus, one transaction at a time.
// Optional feature macro: ARB_TIMEOUT_EN (abort a BUSY phase after
// TIMEOUT_CYC cycles with err=1 and rdata=DEAD_BEEF).
module dark_mem_arbiter
  import dark_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC_DEF
) (
  input  logic                XCLK,
  input  logic                XRES,
  dark_mem_arbiter_if.slave   bus
);

  localparam int IW = $clog2(NREQ);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic [IW-1:0]     r_gnt_id;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     w_winner;
  logic              w_pick_valid;
  logic              w_expire;
  logic              r_mem_we;
  logic [AW-1:0]     r_mem_addr;
  logic [DW-1:0]     r_mem_wdata;
  logic [DW/8-1:0]   r_mem_be;
  logic [DW-1:0]     r_rdata;

  dark_rr_picker #(.N(NREQ)) u_picker (
    .i_req    (bus.req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_winner (w_winner)
  );

  assign bus.mem_req   = (r_state == BUSY);
  assign bus.ack       = (r_state == RESP) ? (NREQ'(1) << r_gnt_id) : '0;
  assign bus.rdata     = r_rdata;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_err;

  assign w_expire = (r_state == BUSY) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign bus.err  = r_err && (r_state == RESP);

  // Count BUSY cycles; held at zero outside BUSY so each transaction starts fresh
  always_ff @(posedge XCLK) begin
    if (XRES || r_state != BUSY) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end

  // Flag an abort when the bus never answered; a same-cycle mem_ack takes priority
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      r_err <= 1'b0;
    end else if (r_state == BUSY) begin
      r_err <= !bus.mem_ack && w_expire;
    end
  end
`else
  assign w_expire = 1'b0;
  assign bus.err  = 1'b0;
`endif

  // State register
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: only IDLE samples requests; mem_ack outside BUSY is ignored
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid) w_state_next = BUSY;
      BUSY:    if (bus.mem_ack || w_expire) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: latch winner's fields, capture read data, rotate priority after the response
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      r_gnt_id    <= '0;
      r_rr_ptr    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_gnt_id    <= w_winner;
            r_mem_we    <= bus.we[w_winner];
            r_mem_addr  <= bus.addr[w_winner];
            r_mem_wdata <= bus.wdata[w_winner];
            r_mem_be    <= bus.be[w_winner];
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            r_rdata <= bus.mem_rdata;
          end else if (w_expire) begin
            r_rdata <= DW'(ARB_ERR_DATA);
          end
        end
        RESP: begin
          r_rr_ptr <= IW'(arb_wrap_inc(int'(r_gnt_id), NREQ));
        end
        default: ;
      endcase
    end
  end

endmodule
